// File: rtl/pipeir_stage.sv
// IF/ID pipeline register with stall hold, flush, and a stall-timeout watchdog FSM.
// Optional performance counters are enabled by defining PIPEIR_PERF_CNT_EN.
module pipeir_stage #(
   parameter int unsigned STALL_LIMIT = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc4,
   input  logic [31:0] ins,
   input  logic        wpcir,
   input  logic        flush,
   output logic [31:0] dpc4,
   output logic [31:0] inst,
   output logic        dvalid,
   output logic        stall_timeout,
   output logic [1:0]  state,
   output logic [31:0] ifetch_cnt,
   output logic [31:0] bubble_cnt
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      HOLD    = 2'b01,
      TIMEOUT = 2'b10
   } state_t;

   localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

   state_t     state_q, state_n;
   logic [7:0] cnt_q, cnt_n;
   logic       load, stall;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      load    = 1'b0;
      stall   = 1'b0;
      if (flush) begin
         state_n = RUN;
         cnt_n   = 8'd0;
      end else if (!wpcir) begin
         stall = 1'b1;
         // The unreachable encoding 2'b11 behaves like RUN and restarts the count.
         case (state_q)
            HOLD, TIMEOUT: cnt_n = sat_inc(cnt_q);
            default:       cnt_n = 8'd1;
         endcase
         state_n = (cnt_n >= LIMIT) ? TIMEOUT : HOLD;
      end else begin
         load    = 1'b1;
         state_n = RUN;
         cnt_n   = 8'd0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= RUN;
         cnt_q         <= 8'd0;
         stall_timeout <= 1'b0;
         dpc4          <= 32'h0;
         inst          <= 32'h0;
         dvalid        <= 1'b0;
      end else begin
         state_q       <= state_n;
         cnt_q         <= cnt_n;
         stall_timeout <= (state_n == TIMEOUT);
         if (flush) begin
            dpc4   <= pc4;
            inst   <= 32'h0;
            dvalid <= 1'b0;
         end else if (load) begin
            dpc4   <= pc4;
            inst   <= ins;
            dvalid <= 1'b1;
         end
      end
   end

   assign state = state_q;

`ifdef PIPEIR_PERF_CNT_EN
   logic [31:0] ifetch_q, bubble_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         ifetch_q <= 32'h0;
         bubble_q <= 32'h0;
      end else begin
         if (load)
            ifetch_q <= ifetch_q + 32'd1;
         if (stall || flush)
            bubble_q <= bubble_q + 32'd1;
      end
   end

   assign ifetch_cnt = ifetch_q;
   assign bubble_cnt = bubble_q;
`else
   assign ifetch_cnt = 32'h0;
   assign bubble_cnt = 32'h0;
`endif

endmodule

// File: doc/pipeir_stage.md
PIPEIR_STAGE -- requirements
Module: pipeir_stage

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 15, range 1..255: consecutive stall cycles that raise stall_timeout.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pc4  input  32  PC+4 from the fetch stage.
REQ-005 SHALL have port ins  input  32  fetched instruction from the fetch stage (already 0 on taken control transfer).
REQ-006 SHALL have port wpcir  input  1  write enable; 0 = stall (hold IF/ID contents).
REQ-007 SHALL have port flush  input  1  discard the current fetch (exception/redirect).
REQ-008 SHALL have port dpc4  output  32  registered PC+4 for the decode stage.
REQ-009 SHALL have port inst  output  32  registered instruction for the decode stage.
REQ-010 SHALL have port dvalid  output  1  inst holds a real fetched instruction.
REQ-011 SHALL have port stall_timeout  output  1  stall has persisted STALL_LIMIT cycles.
REQ-012 SHALL have port state  output  2  FSM state (debug).
REQ-013 SHALL have ports ifetch_cnt and bubble_cnt  output  32 each  performance counters (see Configuration).

Function
REQ-014 SHALL have states RUN=2'b00, HOLD=2'b01, TIMEOUT=2'b10; 2'b11 unreachable, decoded as RUN.
REQ-015 SHALL apply priority per cycle: reset > flush > wpcir=0 (stall) > wpcir=1 (load).
REQ-016 Load: dpc4<=pc4, inst<=ins, dvalid<=1, stall counter<=0, state<=RUN; 1-cycle latency input to output.
REQ-017 Stall: dpc4, inst, dvalid held unchanged; stall counter increments, saturating at 255.
REQ-018 RUN + stall -> HOLD with counter=1; HOLD + stall -> HOLD with counter+1.
REQ-019 HOLD -> TIMEOUT on the same edge the counter reaches STALL_LIMIT; STALL_LIMIT=1 gives RUN -> TIMEOUT directly.
REQ-020 TIMEOUT + stall -> TIMEOUT; stall_timeout=1 exactly while state=TIMEOUT (registered, no combinational path from inputs).
REQ-021 HOLD or TIMEOUT + wpcir=1 -> load per REQ-016; stall_timeout falls on that edge.
REQ-022 Flush (any state, any wpcir): dpc4<=pc4, inst<=32'h0, dvalid<=0, counter<=0, state<=RUN.
REQ-023 dvalid SHALL follow the load path regardless of ins value (ins=0 loaded normally gives dvalid=1).

Reset
REQ-024 On reset=1 at a clock edge: dpc4=0, inst=0, dvalid=0, stall_timeout=0, state=RUN, counter=0, ifetch_cnt=0, bubble_cnt=0.
REQ-025 Reset asserted mid-stall or in TIMEOUT SHALL abandon it; first edge after deassertion obeys REQ-015 normally.

Configuration
REQ-026 Macro PIPEIR_PERF_CNT_EN defined: ifetch_cnt increments on each load edge, bubble_cnt increments on each stall or flush edge; both wrap 32'hFFFFFFFF -> 0; neither counts during reset.
REQ-027 Macro PIPEIR_PERF_CNT_EN undefined: ports ifetch_cnt and bubble_cnt remain, constant 0, no counter registers synthesized; all other behaviour identical.

Verification
REQ-028 Reset 2 cycles, then wpcir=1, pc4=32'h4, ins=32'h8C010000 -> next edge dpc4=32'h4, inst=32'h8C010000, dvalid=1, state=RUN.
REQ-029 After load, wpcir=0 for 3 cycles with pc4/ins changing -> outputs unchanged, state=HOLD, stall_timeout=0; wpcir=1 -> new values loaded, state=RUN.
REQ-030 STALL_LIMIT=15, wpcir=0 for 15 cycles -> stall_timeout rises on 15th edge, state=TIMEOUT; stays 1 at cycle 20; wpcir=1 -> stall_timeout=0 next edge.
REQ-031 flush=1 with wpcir=0 in TIMEOUT, pc4=32'h40 -> inst=0, dvalid=0, dpc4=32'h40, state=RUN, stall_timeout=0.
REQ-032 With PIPEIR_PERF_CNT_EN: 10 loads, 4 stalls, 2 flushes -> ifetch_cnt=10, bubble_cnt=6; forced ifetch_cnt=32'hFFFFFFFF plus 1 load -> 0; without macro both read 0 throughout.
REQ-033 reset=1 asserted in HOLD with counter=7 -> all outputs at REQ-024 values next edge; 15 further stalls needed to re-reach TIMEOUT.
